// File: rtl/minterm_sweep_driver.sv
// Sweep initiator for the 4-input minterm detector; compares out_sop/out_pos against the expected function.
// Latency: code 0 presented from the start edge, one code per accepted handshake, done one cycle after the last handshake.
// Backpressure: holds a..d stable while vec_ready is low; IDLE_GAP idle cycles follow each vector. SWEEP_DC_EN also drives the don't-care codes.
module minterm_sweep_driver #(
    parameter int unsigned IDLE_GAP = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       vec_valid,
    input  logic       vec_ready,
    input  logic       out_sop,
    input  logic       out_pos,
    output logic       busy,
    output logic       done,
    output logic [4:0] err_count,
    output logic [3:0] last_err_code
);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] code, code_nxt;
    logic [3:0] gap_cnt, gap_nxt;
    logic [4:0] err, err_nxt;
    logic [3:0] last, last_nxt;
    logic       expect_one;
    logic       mismatch;
    logic       compare_en;

    // Don't-care codes of the detector: never checked against a response.
    function automatic logic is_dc(input logic [3:0] cv);
        return (cv == 4'd3) || (cv == 4'd8) || (cv == 4'd11) || (cv == 4'd12);
    endfunction

    // Successor in the sweep; code 15 wraps to 0 so a..d read 0 once the sweep ends.
    function automatic logic [3:0] next_code(input logic [3:0] cv);
`ifdef SWEEP_DC_EN
        return cv + 4'd1;
`else
        case (cv)
            4'd2:    return 4'd4;
            4'd7:    return 4'd9;
            4'd10:   return 4'd13;
            default: return cv + 4'd1;
        endcase
`endif
    endfunction

    assign expect_one = (code == 4'd2) || (code == 4'd7) || (code == 4'd15);
    assign mismatch   = (out_sop != expect_one) || (out_pos != expect_one);
    assign compare_en = !is_dc(code);

    assign {a, b, c, d}  = code;
    assign vec_valid     = (state == DRIVE);
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign err_count     = err;
    assign last_err_code = last;

    // Next-state, code advance, gap countdown and mismatch bookkeeping.
    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        gap_nxt   = gap_cnt;
        err_nxt   = err;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (start) begin
                    err_nxt   = 5'd0;
                    last_nxt  = 4'd0;
                    code_nxt  = 4'd0;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (vec_ready) begin
                    if (compare_en && mismatch) begin
                        err_nxt  = (err == 5'd31) ? err : err + 5'd1;
                        last_nxt = code;
                    end
                    code_nxt = next_code(code);
                    if (code == 4'd15) begin
                        state_nxt = DONE;
                    end else if (IDLE_GAP != 0) begin
                        state_nxt = GAP;
                        gap_nxt   = 4'(IDLE_GAP);
                    end
                end
            end
            GAP: begin
                if (gap_cnt <= 4'd1) begin
                    gap_nxt   = 4'd0;
                    state_nxt = DRIVE;
                end else begin
                    gap_nxt = gap_cnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset forces every output low at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            code    <= 4'd0;
            gap_cnt <= 4'd0;
            err     <= 5'd0;
            last    <= 4'd0;
        end else begin
            state   <= state_nxt;
            code    <= code_nxt;
            gap_cnt <= gap_nxt;
            err     <= err_nxt;
            last    <= last_nxt;
        end
    end

endmodule
